sll_iter_shifter: RTL

//  Multi-cycle logical left shifter for the processor ALU path. Companion to the fixed

---
 rtl/sll_iter_shifter_if.sv | 24 ++
 rtl/sll_iter_shifter.sv | 97 +++++++++
 2 files changed

// File: rtl/sll_iter_shifter_if.sv
// Handshake and data bundle for the iterative logical left shifter.
// The requester drives the operands and start; the shifter returns the result and status.
interface sll_iter_shifter_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
);
    logic               ctrl_start;
    logic [WIDTH-1:0]   data_operandA;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic [WIDTH-1:0]   data_result;
    logic               data_exception;
    logic               data_resultRDY;
    logic               busy;

    modport master (
        output ctrl_start, data_operandA, ctrl_shiftamt,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_start, data_operandA, ctrl_shiftamt,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/sll_iter_shifter.sv
// Multi-cycle logical left shifter: one binary stage (16, 8, 4, 2, 1) per cycle,
// fixed latency, with a flag for any set bit shifted out past the MSB.
module sll_iter_shifter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input logic               clock,
    input logic               reset,
    sll_iter_shifter_if.slave bus
);
    localparam int unsigned IdxW = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] amt_q, amt_d;
    logic               lost_q, lost_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;

    logic [31:0]        stage_n;
    logic [WIDTH-1:0]   hi_mask;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            work_q   <= '0;
            amt_q    <= '0;
            lost_q   <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            amt_q    <= amt_d;
            lost_q   <= lost_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        amt_d    = amt_q;
        lost_d   = lost_q;
        idx_d    = idx_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        stage_n  = 32'd1 << idx_q;
        // Selects the top 2**idx bits, i.e. those this stage pushes out.
        hi_mask  = ~({WIDTH{1'b1}} >> stage_n);

        unique case (state_q)
            StIdle: begin
                if (bus.ctrl_start) begin
                    work_d  = bus.data_operandA;
                    amt_d   = bus.ctrl_shiftamt;
                    lost_d  = 1'b0;
                    idx_d   = IdxW'(SHAMT_W - 1);
                    state_d = StShift;
                end
            end
            StShift: begin
                if (amt_q[idx_q]) begin
                    work_d = work_q << stage_n;
                    lost_d = lost_q | (|(work_q & hi_mask));
                end
                if (idx_q == '0) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            StDone: begin
                result_d = work_q;
                exc_d    = lost_q;
                rdy_d    = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = (state_q != StIdle);
endmodule
